mon_mem_responder: RTL

Memory-side responder for the UART monitor's bus interface. It services the monitor's single-outstanding read and write requests (`u_read_req`/`u_write_req`) against the instruction and data RAMs, and returns `read_valid`/`read_data` and `write_finish`. It sits between the monitor and the RAM ports, and yields each port to the CPU whenever the CPU claims it.

---
 rtl/mon_mem_responder_if.sv | 27 ++
 rtl/mon_mem_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mon_mem_responder_if.sv
// Monitor-side request/response bus between the UART monitor and the memory responder.
// The monitor holds a request level until the matching one-cycle completion pulse.
interface mon_mem_responder_if;
   logic        u_read_req;
   logic        u_read_w;
   logic [31:0] u_read_adr;
   logic        read_valid;
   logic [31:0] read_data;
   logic        u_write_req;
   logic        u_write_w;
   logic [31:0] u_write_adr;
   logic [31:0] u_write_data;
   logic        write_finish;
   logic        oor_err;

   modport master (
      output u_read_req, u_read_w, u_read_adr,
      output u_write_req, u_write_w, u_write_adr, u_write_data,
      input  read_valid, read_data, write_finish, oor_err
   );

   modport slave (
      input  u_read_req, u_read_w, u_read_adr,
      input  u_write_req, u_write_w, u_write_adr, u_write_data,
      output read_valid, read_data, write_finish, oor_err
   );
endinterface

// File: rtl/mon_mem_responder.sv
// Services one outstanding monitor read or write against the instruction/data RAM ports,
// yielding each port to the CPU whenever the CPU claims it.
//
// state    | meaning
// IDLE     | sample requests (write wins), latch target, address, data and range check
// RD_ISSUE | wait for port free, then pulse *_re (skipped for out-of-range)
// RD_CAPT  | capture RAM read data (0 if out-of-range), schedule read_valid
// WR_ISSUE | wait for port free, then pulse *_we and schedule write_finish
// DONE     | completion pulse visible, requests ignored
module mon_mem_responder #(
   parameter int IWIDTH = 14,
   parameter int DWIDTH = 14
) (
   input  logic              clk,
   input  logic              rst,
   mon_mem_responder_if.slave bus,
   output logic [IWIDTH-1:0] imem_adr,
   output logic              imem_re,
   output logic              imem_we,
   output logic [31:0]       imem_wdata,
   input  logic [31:0]       imem_rdata,
   output logic [DWIDTH-1:0] dmem_adr,
   output logic              dmem_re,
   output logic              dmem_we,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata,
   input  logic              cpu_imem_busy,
   input  logic              cpu_dmem_busy
);

   typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPT, WR_ISSUE, DONE} state_t;

   state_t            state_q, state_d;
   logic              sel_i_q, sel_i_d;
   logic              oor_q, oor_d;
   logic [IWIDTH-1:0] idx_i_q, idx_i_d;
   logic [DWIDTH-1:0] idx_d_q, idx_d_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       read_data_q, read_data_d;
   logic              read_valid_q, read_valid_d;
   logic              write_finish_q, write_finish_d;
   logic              oor_err_q, oor_err_d;
   logic [IWIDTH-1:0] imem_adr_q, imem_adr_d;
   logic [DWIDTH-1:0] dmem_adr_q, dmem_adr_d;
   logic [31:0]       imem_wdata_q, imem_wdata_d;
   logic [31:0]       dmem_wdata_q, dmem_wdata_d;

   logic              req_w;
   logic [31:0]       req_adr;
   logic              req_oor;
   logic              port_busy;
   logic              unused_adr_lsbs;

   // Write request has priority; the read stays pending until the write completes.
   assign req_w           = bus.u_write_req ? bus.u_write_w   : bus.u_read_w;
   assign req_adr         = bus.u_write_req ? bus.u_write_adr : bus.u_read_adr;
   assign req_oor         = req_w ? (|req_adr[31:IWIDTH+2]) : (|req_adr[31:DWIDTH+2]);
   assign port_busy       = sel_i_q ? cpu_imem_busy : cpu_dmem_busy;
   assign unused_adr_lsbs = ^req_adr[1:0];

   always_comb begin
      state_d        = state_q;
      sel_i_d        = sel_i_q;
      oor_d          = oor_q;
      idx_i_d        = idx_i_q;
      idx_d_d        = idx_d_q;
      wdata_d        = wdata_q;
      read_data_d    = read_data_q;
      read_valid_d   = 1'b0;
      write_finish_d = 1'b0;
      oor_err_d      = 1'b0;
      imem_adr_d     = imem_adr_q;
      dmem_adr_d     = dmem_adr_q;
      imem_wdata_d   = imem_wdata_q;
      dmem_wdata_d   = dmem_wdata_q;
      imem_re        = 1'b0;
      imem_we        = 1'b0;
      dmem_re        = 1'b0;
      dmem_we        = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.u_write_req || bus.u_read_req) begin
               sel_i_d = req_w;
               oor_d   = req_oor;
               idx_i_d = req_adr[IWIDTH+1:2];
               idx_d_d = req_adr[DWIDTH+1:2];
               wdata_d = bus.u_write_data;
               state_d = bus.u_write_req ? WR_ISSUE : RD_ISSUE;
            end
         end
         RD_ISSUE: begin
            if (oor_q) begin
               state_d = RD_CAPT;
            end else if (!port_busy) begin
               if (sel_i_q) begin
                  imem_re    = 1'b1;
                  imem_adr_d = idx_i_q;
               end else begin
                  dmem_re    = 1'b1;
                  dmem_adr_d = idx_d_q;
               end
               state_d = RD_CAPT;
            end
         end
         RD_CAPT: begin
            read_data_d  = oor_q ? 32'h0 : (sel_i_q ? imem_rdata : dmem_rdata);
            read_valid_d = 1'b1;
            oor_err_d    = oor_q;
            state_d      = DONE;
         end
         WR_ISSUE: begin
            if (oor_q || !port_busy) begin
               if (!oor_q && sel_i_q) begin
                  imem_we      = 1'b1;
                  imem_adr_d   = idx_i_q;
                  imem_wdata_d = wdata_q;
               end else if (!oor_q) begin
                  dmem_we      = 1'b1;
                  dmem_adr_d   = idx_d_q;
                  dmem_wdata_d = wdata_q;
               end
               write_finish_d = 1'b1;
               oor_err_d      = oor_q;
               state_d        = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         sel_i_q        <= 1'b0;
         oor_q          <= 1'b0;
         idx_i_q        <= '0;
         idx_d_q        <= '0;
         wdata_q        <= '0;
         read_data_q    <= '0;
         read_valid_q   <= 1'b0;
         write_finish_q <= 1'b0;
         oor_err_q      <= 1'b0;
         imem_adr_q     <= '0;
         dmem_adr_q     <= '0;
         imem_wdata_q   <= '0;
         dmem_wdata_q   <= '0;
      end else begin
         state_q        <= state_d;
         sel_i_q        <= sel_i_d;
         oor_q          <= oor_d;
         idx_i_q        <= idx_i_d;
         idx_d_q        <= idx_d_d;
         wdata_q        <= wdata_d;
         read_data_q    <= read_data_d;
         read_valid_q   <= read_valid_d;
         write_finish_q <= write_finish_d;
         oor_err_q      <= oor_err_d;
         imem_adr_q     <= imem_adr_d;
         dmem_adr_q     <= dmem_adr_d;
         imem_wdata_q   <= imem_wdata_d;
         dmem_wdata_q   <= dmem_wdata_d;
      end
   end

   // Address/wdata present the new value during the strobe cycle and hold it afterwards.
   assign imem_adr         = imem_adr_d;
   assign dmem_adr         = dmem_adr_d;
   assign imem_wdata       = imem_wdata_d;
   assign dmem_wdata       = dmem_wdata_d;
   assign bus.read_valid   = read_valid_q;
   assign bus.read_data    = read_data_q;
   assign bus.write_finish = write_finish_q;
   assign bus.oor_err      = oor_err_q;

endmodule
